// File: rtl/uart_transmitter_pkg.sv
`timescale 1ns/100ps
// Shared state encoding and constants for the message-beacon UART transmitter.
package uart_transmitter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } state_e;

  localparam int MSG_LEN              = 15;
  localparam int DEFAULT_DELAY_FRAMES = 234;
  localparam int DEFAULT_GAP_BITS     = 10;

endpackage

// File: rtl/uart_transmitter_msg_rom.sv
`timescale 1ns/100ps
// Combinational message ROM: "Hello, World!" followed by CR LF.
// Addresses past the message read back as an ASCII space.
module uart_tx_msg_rom (
  input  logic [3:0] addr,
  output logic [7:0] data
);

  always_comb begin
    case (addr)
      4'd0:    data = 8'h48;
      4'd1:    data = 8'h65;
      4'd2:    data = 8'h6C;
      4'd3:    data = 8'h6C;
      4'd4:    data = 8'h6F;
      4'd5:    data = 8'h2C;
      4'd6:    data = 8'h20;
      4'd7:    data = 8'h57;
      4'd8:    data = 8'h6F;
      4'd9:    data = 8'h72;
      4'd10:   data = 8'h6C;
      4'd11:   data = 8'h64;
      4'd12:   data = 8'h21;
      4'd13:   data = 8'h0D;
      4'd14:   data = 8'h0A;
      default: data = 8'h20;
    endcase
  end

endmodule

// File: rtl/uart_transmitter.sv
`timescale 1ns/100ps
// Free-running 8N1 UART beacon that repeats a fixed message, followed by
// GAP_BITS idle bit-times, forever.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
  parameter int GAP_BITS     = DEFAULT_GAP_BITS
) (
  input  logic clk,
  input  logic rst,
  output logic uart_tx
);

  localparam int TIMER_W = $clog2(DELAY_FRAMES);
  localparam int GAP_W   = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(DELAY_FRAMES - 1);
  localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [3:0]         LAST_BYTE = 4'(MSG_LEN - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [3:0]         byte_idx_q, byte_idx_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]         cur_byte_q, cur_byte_d;
  logic               tx_q, tx_d;
  logic               bit_done;
  logic [3:0]         rom_addr;
  logic [7:0]         rom_byte;

  // The ROM is addressed with the byte about to be framed, so it can be
  // latched on the same edge that enters START.
  assign rom_addr = (state_q == STOP && byte_idx_q != LAST_BYTE) ? byte_idx_q + 4'd1 : 4'd0;

  uart_tx_msg_rom u_rom (
    .addr (rom_addr),
    .data (rom_byte)
  );

  assign bit_done = (timer_q == TIMER_MAX);

  always_comb begin
    state_d    = state_q;
    timer_d    = bit_done ? '0 : timer_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    cur_byte_d = cur_byte_q;

    case (state_q)
      IDLE: begin
        if (bit_done) begin
          state_d    = START;
          byte_idx_d = 4'd0;
          cur_byte_d = rom_byte;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (byte_idx_q != LAST_BYTE) begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 4'd1;
            cur_byte_d = rom_byte;
          end else if (GAP_BITS == 0) begin
            state_d    = START;
            byte_idx_d = 4'd0;
            cur_byte_d = rom_byte;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
      end
      GAP: begin
        if (bit_done) begin
          if (gap_cnt_q == GAP_MAX) begin
            state_d    = START;
            byte_idx_d = 4'd0;
            cur_byte_d = rom_byte;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered, so it is registered with it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      gap_cnt_q  <= '0;
      cur_byte_q <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      cur_byte_q <= cur_byte_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/100ps
// Bench for uart_transmitter: decodes the serial line frame by frame against a
// byte table, and spot-checks random instants against a message-level line model.
module tb_uart_transmitter;

  localparam int D_MAIN  = 234;
  localparam int G_MAIN  = 10;
  localparam int D_SMALL = 4;
  localparam int G_SMALL = 0;
  localparam int MSG_LEN = 15;

  typedef struct {
    int         idx;
    logic [7:0] expByte;
  } vec_t;

  logic clk = 1'b0;
  logic rstMain;
  logic rstSmall;
  logic sel;
  logic txMain;
  logic txSmall;
  logic txMon;

  int cyc = 0;
  int base = 0;
  int vecCount = 0;
  int missCount = 0;

  vec_t       vecs[MSG_LEN];
  logic [7:0] msgModel[MSG_LEN];

  uart_transmitter dutMain (
    .clk     (clk),
    .rst     (rstMain),
    .uart_tx (txMain)
  );

  uart_transmitter #(
    .DELAY_FRAMES (D_SMALL),
    .GAP_BITS     (G_SMALL)
  ) dutSmall (
    .clk     (clk),
    .rst     (rstSmall),
    .uart_tx (txSmall)
  );

  assign txMon = sel ? txSmall : txMain;

  // 37 ns period, roughly 27 MHz.
  always #18.5 clk = ~clk;

  // Free-running edge count; times are taken relative to the last reset release.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int relNow();
    return cyc - base;
  endfunction

  // Expected line level after t rising edges since reset release, from the
  // message timing rules: one idle bit, then 15 ten-bit frames and g idle bits, repeating.
  function automatic logic modelTx(int t, int d, int g);
    int period, u, f, b;
    if (t < d) return 1'b1;
    period = (MSG_LEN * 10 + g) * d;
    u = (t - d) % period;
    if (u >= MSG_LEN * 10 * d) return 1'b1;
    f = u / (10 * d);
    b = (u % (10 * d)) / d;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return msgModel[f][b-1];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic toSmall, input logic level);
    if (toSmall) rstSmall = level;
    else         rstMain  = level;
  endtask

  task automatic waitFall(input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (txMon === 1'b0) begin
        at = relNow();
        break;
      end
    end
  endtask

  // Entered on the first sampled cycle of a start bit; leaves exactly one frame later.
  task automatic decodeFrame(input int d, input int frameNo, input logic [7:0] expByte,
                             input logic expNext, output int startRel);
    logic       startBit, stopBit, endStop, nextBit;
    logic [7:0] data;
    startRel = relNow();
    repeat (d / 2) @(negedge clk);
    startBit = txMon;
    for (int k = 0; k < 8; k++) begin
      repeat (d) @(negedge clk);
      data[k] = txMon;
    end
    repeat (d) @(negedge clk);
    stopBit = txMon;
    repeat (d - d / 2 - 1) @(negedge clk);
    endStop = txMon;
    @(negedge clk);
    nextBit = txMon;
    checkOutput($sformatf("frame%0d_start", frameNo), {31'd0, startBit}, 32'd0);
    checkOutput($sformatf("frame%0d_data", frameNo), {24'd0, data}, {24'd0, expByte});
    checkOutput($sformatf("frame%0d_stop", frameNo), {31'd0, stopBit}, 32'd1);
    checkOutput($sformatf("frame%0d_edge", frameNo), {30'd0, endStop, nextBit}, {30'd0, 1'b1, expNext});
  endtask

  initial begin
    int    at;
    int    startRel;
    int    lfStart;
    logic  ok;
    string s;

    vecs = '{'{0, 8'h48}, '{1, 8'h65}, '{2, 8'h6C}, '{3, 8'h6C}, '{4, 8'h6F},
             '{5, 8'h2C}, '{6, 8'h20}, '{7, 8'h57}, '{8, 8'h6F}, '{9, 8'h72},
             '{10, 8'h6C}, '{11, 8'h64}, '{12, 8'h21}, '{13, 8'h0D}, '{14, 8'h0A}};
    s = "Hello, World!";
    for (int i = 0; i < 13; i++) msgModel[i] = s[i];
    msgModel[13] = 8'h0D;
    msgModel[14] = 8'h0A;

    sel = 1'b0;
    at = 0;
    startRel = 0;
    lfStart = 0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);

    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_hold", {31'd0, txMain}, 32'd1);
    end
    #30;
    @(negedge clk);
    checkOutput("reset_hold_end", {31'd0, txMain}, 32'd1);
    applyStimulus(1'b0, 1'b1);
    base = cyc;

    ok = 1'b1;
    repeat (D_MAIN - 1) begin
      @(negedge clk);
      if (txMain !== 1'b1) ok = 1'b0;
    end
    checkOutput("idle_bit_time", {31'd0, ok}, 32'd1);
    waitFall(3 * D_MAIN, at);
    checkOutput("first_start_cycle", at, D_MAIN);

    for (int i = 0; i < 3; i++) decodeFrame(D_MAIN, i, vecs[i].expByte, 1'b0, startRel);

    // Land mid-way through bit 0 of byte 3 ('l', bit 0 low), then reset between clock edges.
    repeat (D_MAIN + D_MAIN / 2) @(negedge clk);
    checkOutput("byte3_bit0", {31'd0, txMain}, {31'd0, modelTx(relNow(), D_MAIN, G_MAIN)});
    #5 applyStimulus(1'b0, 1'b0);
    #1 checkOutput("async_reset", {31'd0, txMain}, 32'd1);
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (txMain !== 1'b1) ok = 1'b0;
    end
    checkOutput("mid_reset_hold", {31'd0, ok}, 32'd1);
    applyStimulus(1'b0, 1'b1);
    base = cyc;
    waitFall(3 * D_MAIN, at);
    checkOutput("restart_start_cycle", at, D_MAIN);

    for (int i = 0; i < MSG_LEN; i++) begin
      decodeFrame(D_MAIN, i, vecs[i].expByte, (i == MSG_LEN - 1), startRel);
      if (i == MSG_LEN - 1) lfStart = startRel;
    end

    repeat (8) begin
      repeat ($urandom_range(1, 200)) @(negedge clk);
      checkOutput("gap_model", {31'd0, txMain}, {31'd0, modelTx(relNow(), D_MAIN, G_MAIN)});
    end
    waitFall(G_MAIN * D_MAIN + 2 * D_MAIN, at);
    checkOutput("lf_to_next_start", at - lfStart, 10 * D_MAIN + G_MAIN * D_MAIN);

    for (int i = 0; i < MSG_LEN; i++)
      decodeFrame(D_MAIN, MSG_LEN + i, vecs[i].expByte, (i == MSG_LEN - 1), startRel);

    sel = 1'b1;
    @(negedge clk);
    checkOutput("small_reset_hold", {31'd0, txSmall}, 32'd1);
    applyStimulus(1'b1, 1'b1);
    base = cyc;
    waitFall(3 * D_SMALL, at);
    checkOutput("small_first_start_cycle", at, D_SMALL);

    // With no gap, the LF frame runs straight into the start bit of the next 'H'.
    for (int i = 0; i <= MSG_LEN; i++)
      decodeFrame(D_SMALL, 100 + i, vecs[i % MSG_LEN].expByte, 1'b0, startRel);

    repeat (40) begin
      repeat ($urandom_range(1, 25)) @(negedge clk);
      checkOutput("small_model", {31'd0, txSmall}, {31'd0, modelTx(relNow(), D_SMALL, G_SMALL)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
